// File: rtl/traffic_pkg.sv
// Shared definitions for the junction phase scheduler: phase encodings,
// signal-head colour codes and the head decode helper.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_2  = 3'd5,
        PED_WALK  = 3'd6
    } phase_t;

    localparam logic [2:0] RYG_RED = 3'b100;
    localparam logic [2:0] RYG_YEL = 3'b010;
    localparam logic [2:0] RYG_GRN = 3'b001;

    // A head shows green/yellow only in its own green/yellow phase, red otherwise.
    function automatic logic [2:0] head_ryg(input phase_t p, input phase_t grn, input phase_t yel);
        if (p == grn) begin
            return RYG_GRN;
        end else if (p == yel) begin
            return RYG_YEL;
        end else begin
            return RYG_RED;
        end
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase dwell counter: cleared on the cycle a new phase is entered,
// then counts up once per cycle and sticks at its all-ones value.
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != {CNT_W{1'b1}}) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Actuated two-road junction sequencer: NS/EW green-yellow-allred cycle with
// an optional pedestrian walk phase inserted after either all-red clearance.
module junction_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic [2:0] ns_out,
    output logic [2:0] ew_out,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] GMIN_END  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_END  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_END   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_END    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_END  = CNT_W'(WALK_T - 1);

    phase_t           state;
    phase_t           state_nx;
    logic             entering;
    logic             ped_pending;
    logic             next_is_ew;
    logic [CNT_W-1:0] timer;

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (entering),
        .count (timer)
    );

    // Next-phase selection. The max-green test uses >= so that a green which
    // rested past GREEN_MAX with no rival cannot starve a late-arriving rival.
    always_comb begin
        state_nx = state;
        case (state)
            NS_GREEN: begin
                if (timer >= GMIN_END && (ew_req || ped_pending) && (!ns_req || timer >= GMAX_END)) begin
                    state_nx = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (timer == YEL_END) begin
                    state_nx = ALLRED_1;
                end
            end
            ALLRED_1: begin
                if (timer == AR_END) begin
                    state_nx = ped_pending ? PED_WALK : EW_GREEN;
                end
            end
            EW_GREEN: begin
                if (timer >= GMIN_END && (ns_req || ped_pending) && (!ew_req || timer >= GMAX_END)) begin
                    state_nx = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (timer == YEL_END) begin
                    state_nx = ALLRED_2;
                end
            end
            ALLRED_2: begin
                if (timer == AR_END) begin
                    state_nx = ped_pending ? PED_WALK : NS_GREEN;
                end
            end
            PED_WALK: begin
                if (timer == WALK_END) begin
                    state_nx = next_is_ew ? EW_GREEN : NS_GREEN;
                end
            end
            default: begin
                state_nx = ALLRED_2;
            end
        endcase
        entering = (state_nx != state);
    end

    // Phase register, pedestrian bookkeeping and registered head outputs;
    // outputs are decoded from state_nx so they always mirror the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ALLRED_2;
            ped_pending <= 1'b0;
            next_is_ew  <= 1'b0;
            ns_out      <= RYG_RED;
            ew_out      <= RYG_RED;
            walk        <= 1'b0;
            phase       <= ALLRED_2;
        end else begin
            state <= state_nx;

            if (state != PED_WALK && state_nx == PED_WALK) begin
                ped_pending <= 1'b0;
            end else if (ped_req && state != PED_WALK) begin
                ped_pending <= 1'b1;
            end

            if (state == ALLRED_1 && entering) begin
                next_is_ew <= 1'b1;
            end else if (state == ALLRED_2 && entering) begin
                next_is_ew <= 1'b0;
            end

            ns_out <= head_ryg(state_nx, NS_GREEN, NS_YELLOW);
            ew_out <= head_ryg(state_nx, EW_GREEN, EW_YELLOW);
            walk   <= (state_nx == PED_WALK);
            phase  <= state_nx;
        end
    end

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Self-checking bench for junction_phase_scheduler: a cycle model feeds a
// scoreboard queue, and a negedge monitor checks head safety and phase lengths.
module tb_junction_phase_scheduler;
    import traffic_pkg::*;

    localparam int GREEN_MIN = 8;
    localparam int GREEN_MAX = 20;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 6;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_out;
    logic [2:0] ew_out;
    logic       walk;
    logic [2:0] phase;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic [2:0] phase;
    } exp_t;

    exp_t sbq[$];

    phase_t m_state;
    int     m_cnt;
    logic   m_ped;
    logic   m_next_ew;

    logic [2:0] prev_ns, prev_ew;
    logic       prev_walk;
    int         len_ns, len_ew, len_walk;
    int         last_ns_green = 0;
    int         last_ew_green = 0;
    int         last_walk = 0;
    int         walk_runs = 0;
    int         w0;

    junction_phase_scheduler dut (
        .clk     (clk),
        .rst     (rst),
        .ns_req  (ns_req),
        .ew_req  (ew_req),
        .ped_req (ped_req),
        .ns_out  (ns_out),
        .ew_out  (ew_out),
        .walk    (walk),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic exp_t model_outputs(input phase_t s);
        exp_t e;
        e.ns    = (s == NS_GREEN) ? GRN : (s == NS_YELLOW) ? YEL : RED;
        e.ew    = (s == EW_GREEN) ? GRN : (s == EW_YELLOW) ? YEL : RED;
        e.walk  = (s == PED_WALK);
        e.phase = s;
        return e;
    endfunction

    task automatic modelReset();
        m_state   = ALLRED_2;
        m_cnt     = 0;
        m_ped     = 1'b0;
        m_next_ew = 1'b0;
    endtask

    // One clock of the reference model, using this cycle's request inputs.
    task automatic modelStep(input logic n, input logic e, input logic p);
        phase_t nx;
        nx = m_state;
        case (m_state)
            NS_GREEN:  if (m_cnt >= GREEN_MIN - 1 && (e || m_ped) && (!n || m_cnt >= GREEN_MAX - 1)) nx = NS_YELLOW;
            EW_GREEN:  if (m_cnt >= GREEN_MIN - 1 && (n || m_ped) && (!e || m_cnt >= GREEN_MAX - 1)) nx = EW_YELLOW;
            NS_YELLOW: if (m_cnt == YELLOW_T - 1) nx = ALLRED_1;
            EW_YELLOW: if (m_cnt == YELLOW_T - 1) nx = ALLRED_2;
            ALLRED_1: if (m_cnt == ALLRED_T - 1) begin
                nx = m_ped ? PED_WALK : EW_GREEN;
                m_next_ew = 1'b1;
            end
            ALLRED_2: if (m_cnt == ALLRED_T - 1) begin
                nx = m_ped ? PED_WALK : NS_GREEN;
                m_next_ew = 1'b0;
            end
            PED_WALK:  if (m_cnt == WALK_T - 1) nx = m_next_ew ? EW_GREEN : NS_GREEN;
            default:   nx = ALLRED_2;
        endcase
        if (m_state != PED_WALK) begin
            if (nx == PED_WALK) m_ped = 1'b0;
            else if (p) m_ped = 1'b1;
        end
        m_cnt   = (nx != m_state) ? 0 : ((m_cnt < 31) ? m_cnt + 1 : 31);
        m_state = nx;
    endtask

    task automatic applyStimulus(input logic n, input logic e, input logic p);
        exp_t got;
        exp_t want;
        ns_req  = n;
        ew_req  = e;
        ped_req = p;
        modelStep(n, e, p);
        sbq.push_back(model_outputs(m_state));
        @(posedge clk);
        #1;
        want = sbq.pop_front();
        got.ns = ns_out; got.ew = ew_out; got.walk = walk; got.phase = phase;
        checkOutput("sb_ns", 32'(got.ns), 32'(want.ns));
        checkOutput("sb_ew", 32'(got.ew), 32'(want.ew));
        checkOutput("sb_walk", 32'(got.walk), 32'(want.walk));
        checkOutput("sb_phase", 32'(got.phase), 32'(want.phase));
    endtask

    // Reset lands a few ns after the last edge, so outputs must clear before any clock.
    task automatic applyReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_ns", 32'(ns_out), 32'(RED));
        checkOutput("rst_ew", 32'(ew_out), 32'(RED));
        checkOutput("rst_walk", 32'(walk), 32'(1'b0));
        checkOutput("rst_phase", 32'(phase), 32'(ALLRED_2));
        modelReset();
        sbq.delete();
        repeat (2) @(negedge clk);
        #1;
        ns_req  = 1'b0;
        ew_req  = 1'b0;
        ped_req = 1'b0;
        rst = 1'b0;
    endtask

    // Safety and phase-length monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_ns = RED; prev_ew = RED; prev_walk = 1'b0;
            len_ns = 0; len_ew = 0; len_walk = 0;
        end else begin
            checkOutput("head_conflict", 32'(ns_out != RED && ew_out != RED), 32'(0));
            checkOutput("walk_not_red", 32'(walk && (ns_out != RED || ew_out != RED)), 32'(0));
            if (ns_out == prev_ns) len_ns++;
            else begin
                if (prev_ns == GRN) begin
                    last_ns_green = len_ns;
                    checkOutput("ns_green_min", 32'(len_ns >= GREEN_MIN), 32'(1));
                end
                if (prev_ns == YEL) checkOutput("ns_yellow_len", 32'(len_ns), 32'(YELLOW_T));
                prev_ns = ns_out;
                len_ns = 1;
            end
            if (ew_out == prev_ew) len_ew++;
            else begin
                if (prev_ew == GRN) begin
                    last_ew_green = len_ew;
                    checkOutput("ew_green_min", 32'(len_ew >= GREEN_MIN), 32'(1));
                end
                if (prev_ew == YEL) checkOutput("ew_yellow_len", 32'(len_ew), 32'(YELLOW_T));
                prev_ew = ew_out;
                len_ew = 1;
            end
            if (walk == prev_walk) len_walk++;
            else begin
                if (prev_walk) begin
                    last_walk = len_walk;
                    walk_runs++;
                end
                prev_walk = walk;
                len_walk = 1;
            end
        end
    end

    initial begin
        $display("[TB] junction_phase_scheduler bench start");

        // Idle junction rests in NS green after one all-red cycle.
        applyReset();
        repeat (55) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_ns_green", 32'(ns_out), 32'(GRN));
        checkOutput("t1_ew_red", 32'(ew_out), 32'(RED));
        checkOutput("t1_hold_len", 32'(len_ns >= 50), 32'(1));

        // EW demand from green cycle 2 gives minimum green then yellow/allred.
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t2_ns_green_len", 32'(last_ns_green), 32'(GREEN_MIN));
        checkOutput("t2_ew_green", 32'(ew_out), 32'(GRN));

        // Both roads busy: each green extends to the maximum.
        applyReset();
        repeat (70) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t3_ns_green_len", 32'(last_ns_green), 32'(GREEN_MAX));
        checkOutput("t3_ew_green_len", 32'(last_ew_green), 32'(GREEN_MAX));

        // Pedestrian pulse in NS green: one walk phase, then EW green.
        applyReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        w0 = walk_runs;
        for (int i = 0; i < 40 && !walk; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_walk_start", 32'(walk), 32'(1'b1));
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_walk_len", 32'(last_walk), 32'(WALK_T));
        checkOutput("t4_walk_runs", 32'(walk_runs - w0), 32'(1));
        checkOutput("t4_ew_green", 32'(ew_out), 32'(GRN));

        // Reset during NS yellow with a walk pending discards the walk.
        applyReset();
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 30 && ns_out != YEL; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t5_reach_yellow", 32'(ns_out), 32'(YEL));
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyReset();
        w0 = walk_runs;
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5_no_walk", 32'(walk_runs - w0), 32'(0));
        checkOutput("t5_ns_green", 32'(ns_out), 32'(GRN));

        // Randomised traffic with occasional asynchronous resets.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 199) == 0) applyReset();
            else applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
